// File: rtl/lca_32.sv
// ----------------------------------------------------------------------------
// lca_32 -- registered 32-bit two-level carry-lookahead adder.
//
// Computes {C2, F} = A + B + C0 (modulo 2^32 with carry-out) and captures the
// result in output registers on every rising clock edge (latency 1, one
// operand set accepted per cycle).
//
// Carry structure:
//   - 8 four-bit cells, each producing group generate/propagate (G, P) and
//     fully expanded internal carries from its cell carry-in.
//   - 2 sixteen-bit lookahead units, each taking 4 cells' G/P plus the group
//     carry-in and producing the cell carry-ins, G16 and P16.
//   - A top-level lookahead across the two halves producing C1 (carry into
//     bit 16, internal) and the carry-out.
// No carry ripples across more than one bit; every carry is a lookahead term.
//
// Ports:
//   clk  in   1   system clock, rising edge
//   rst  in   1   synchronous active-high reset (F=0, C2=0)
//   A    in   32  addend
//   B    in   32  addend
//   C0   in   1   carry-in to bit 0
//   F    out  32  registered sum
//   C2   out  1   registered carry-out of bit 31
// ----------------------------------------------------------------------------
module lca_32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        C0,
    output logic [31:0] F,
    output logic        C2
);

    // Carries into positions 0..3 of a 4-wide lookahead block, fully expanded
    // from the block carry-in. Used both for bit carries inside a cell and for
    // cell carries inside a 16-bit group.
    function automatic logic [3:0] la_carry(input logic [3:0] g,
                                            input logic [3:0] p,
                                            input logic       ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    // Block generate (bit 1) and propagate (bit 0) of a 4-wide block.
    function automatic logic [1:0] la_gp(input logic [3:0] g,
                                         input logic [3:0] p);
        logic gg;
        logic pp;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
        pp = &p;
        return {gg, pp};
    endfunction

    logic [31:0] g_bit;
    logic [31:0] p_bit;
    logic [31:0] c_bit;
    logic [7:0]  cell_g;
    logic [7:0]  cell_p;
    logic [7:0]  cell_cin;
    logic [1:0]  gp16_lo;
    logic [1:0]  gp16_hi;
    logic        c1;
    logic        cout;

    logic [31:0] f_d;
    logic [31:0] f_q;
    logic        c2_d;
    logic        c2_q;

    assign g_bit = A & B;
    assign p_bit = A ^ B;

    // Level 1: per-cell group generate/propagate, independent of carry-in.
    for (genvar k = 0; k < 8; k++) begin : g_cell_gp
        assign {cell_g[k], cell_p[k]} = la_gp(g_bit[4*k +: 4], p_bit[4*k +: 4]);
    end

    // Level 2: 16-bit group G/P from the four cells of each half.
    assign gp16_lo = la_gp(cell_g[3:0], cell_p[3:0]);
    assign gp16_hi = la_gp(cell_g[7:4], cell_p[7:4]);

    // Top level: carries across the two halves, both taken straight from C0.
    assign c1   = gp16_lo[1] | (gp16_lo[0] & C0);
    assign cout = gp16_hi[1] | (gp16_hi[0] & gp16_lo[1])
                | (gp16_hi[0] & gp16_lo[0] & C0);

    // Level 2: cell carry-ins within each half.
    assign cell_cin[3:0] = la_carry(cell_g[3:0], cell_p[3:0], C0);
    assign cell_cin[7:4] = la_carry(cell_g[7:4], cell_p[7:4], c1);

    // Level 1: bit carries inside each cell from its cell carry-in.
    for (genvar k = 0; k < 8; k++) begin : g_cell_carry
        assign c_bit[4*k +: 4] = la_carry(g_bit[4*k +: 4], p_bit[4*k +: 4],
                                          cell_cin[k]);
    end

    assign f_d  = p_bit ^ c_bit;
    assign c2_d = cout;

    // Output register stage; reset overrides the incoming operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_q  <= 32'h0000_0000;
            c2_q <= 1'b0;
        end else begin
            f_q  <= f_d;
            c2_q <= c2_d;
        end
    end

    assign F  = f_q;
    assign C2 = c2_q;

endmodule

// File: tb/tb_lca_32.sv
module tb_lca_32;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic        C0;
    logic [31:0] F;
    logic        C2;

    int total;
    int bad;

    lca_32 dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .C0  (C0),
        .F   (F),
        .C2  (C2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] obs,
                         input logic [32:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply operands, clock one edge, then sample just after the edge.
    task automatic step(input logic [31:0] a, input logic [31:0] b,
                        input logic c);
        A  = a;
        B  = b;
        C0 = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic [32:0] ref_sum;

        total = 0;
        bad   = 0;

        // Reset held for two edges with operands that would otherwise carry.
        rst = 1'b1;
        step(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        check("reset_edge1", {C2, F}, 33'h0_0000_0000);
        step(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        check("reset_edge2", {C2, F}, 33'h0_0000_0000);

        // First edge after release loads the operands present.
        rst = 1'b0;
        step(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        check("after_reset", {C2, F}, 33'h1_0000_0001);

        // Directed vectors on consecutive cycles.
        step(32'h0000_0000, 32'h0000_0000, 1'b0);
        check("zero", {C2, F}, 33'h0_0000_0000);
        step(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        check("full_carry", {C2, F}, 33'h1_0000_0000);
        step(32'h0000_FFFF, 32'hFFFF_0000, 1'b1);
        check("cross_half_prop", {C2, F}, 33'h1_0000_0000);
        step(32'h0000_0900, 32'h0000_0100, 1'b1);
        check("mid_field", {C2, F}, 33'h0_0000_0A01);

        // Extra boundaries: propagate-only halves and cell-boundary carries.
        step(32'h0000_FFFF, 32'hFFFF_0000, 1'b0);
        check("all_prop_no_cin", {C2, F}, 33'h0_FFFF_FFFF);
        step(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        check("carry_into_16", {C2, F}, 33'h0_0001_0000);
        step(32'h0000_000F, 32'h0000_0000, 1'b1);
        check("carry_into_4", {C2, F}, 33'h0_0000_0010);
        step(32'h8000_0000, 32'h8000_0000, 1'b0);
        check("msb_generate", {C2, F}, 33'h1_0000_0000);
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("all_ones", {C2, F}, 33'h1_FFFF_FFFF);
        step(32'h1234_5678, 32'h8765_4321, 1'b0);
        check("pattern", {C2, F}, 33'h0_9999_9999);

        // Reset mid-stream discards the in-flight result.
        rst = 1'b1;
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("midstream_reset", {C2, F}, 33'h0_0000_0000);
        rst = 1'b0;
        step(32'h0000_0002, 32'h0000_0003, 1'b0);
        check("post_midstream", {C2, F}, 33'h0_0000_0005);

        // Random operands, one per cycle, against the 33-bit reference.
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            ref_sum = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
            step(ra, rb, rc);
            check("random", {C2, F}, ref_sum);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lca_32.md
# lca_32

Registered 32-bit two-level carry-lookahead adder. It computes F = A + B + C0 with carry-out C2, using 4-bit lookahead cells, 16-bit group lookahead and a top-level lookahead across the two 16-bit halves. It sits in the datapath as the integer adder stage. The sum and carry-out are captured in output registers on each clock edge.

## Interface

No parameters. The width is fixed at 32 bits.

Ports:
- clk  input  1  — system clock; all state updates on the rising edge.
- rst  input  1  — synchronous, active-high reset, sampled on the rising edge of clk.
- A  input  32  — addend, unsigned or two's complement.
- B  input  32  — addend.
- C0  input  1  — carry-in to bit 0.
- F  output  32  — registered sum bits [31:0].
- C2  output  1  — registered carry-out of bit 31.

## Operation

- Per bit i: g_i = A[i] & B[i], p_i = A[i] ^ B[i], F_i = p_i ^ c_i.
- Level 1 (4-bit cell, ×8):
  - Internal carries are fully parallel: c_{i+1} = g_i | p_i·c_i, expanded so there is no ripple inside the cell.
  - Each cell outputs group generate G and group propagate P.
- Level 2 (16-bit group, ×2):
  - A lookahead unit takes the 4 cells' G/P plus the group carry-in.
  - It produces the cell carry-ins (bits 4, 8, 12 relative to the group), group G16 and group P16.
- Top level:
  - C1 (carry into bit 16) = G16_lo | P16_lo·C0.
  - Carry-out = G16_hi | P16_hi·G16_lo | P16_hi·P16_lo·C0.
  - C1 is internal only and is not a port.
- The combinational sum and carry-out feed the output registers.
- Arithmetic is modulo 2^32. Overflow is reported only through C2; there is no signed-overflow flag.
- No ripple path may span more than one bit. All carries must come from lookahead equations.

## Timing

- Latency is one cycle. A, B and C0 are sampled on rising edge N. F and C2 hold the result from edge N until edge N+1.
- No handshake. The block accepts a new operand set every cycle (throughput 1/cycle).
- Reset: when rst=1 at a rising edge, F=32'h0000_0000 and C2=0, regardless of the inputs.
  - Reset has priority over the new operands.
  - On the first edge after rst deasserts, the registers load the operands present at that edge.
- Reset asserted mid-stream discards the in-flight result. The next valid result appears one edge after rst returns to 0.
- Before the first reset the outputs are undefined. Verification only checks them after reset.
- The combinational path A/B/C0 → register D must close within one clock period. The design's critical path is about 4 lookahead levels, not 32 ripple stages.

## Test plan

- Reset: hold rst=1 for 2 cycles with A=32'hFFFF_FFFF, B=1, C0=1 → F=0, C2=0 every cycle. After release, the next edge gives F=32'h0000_0001, C2=1.
- Zero: A=0, B=0, C0=0 → one edge later F=32'h0000_0000, C2=0.
- Full-width carry: A=32'hFFFF_FFFF, B=32'h0000_0001, C0=0 → F=32'h0000_0000, C2=1. This exercises the carry chain through every cell and both halves.
- Cross-half propagate with carry-in: A=32'h0000_FFFF, B=32'hFFFF_0000, C0=1 → F=32'h0000_0000, C2=1. All bits propagate, so C0 reaches C2 through C1.
- Mid-field add: A=32'h0000_0900, B=32'h0000_0100, C0=1 → F=32'h0000_0A01, C2=0.
- Back-to-back and random:
  - Apply the four vectors above on consecutive cycles. Each result must appear exactly one edge after its inputs, with no stalls.
  - Then run ≥10k random {A, B, C0}, comparing {C2, F} against the 33-bit reference A+B+C0 delayed one cycle.
